// File: rtl/imem_fill_resp_pkg.sv
// Shared configuration for the L1 I-cache fill responder: default widths, beat count and FSM encodings.
// Also used by the optional next-line prefetch build (IMEM_RESP_PREFETCH_EN).
package imem_fill_resp_pkg;

  localparam int BLK_LEN_DEF = 59;
  localparam int LINE_W_DEF  = 256;
  localparam int MEM_W_DEF   = 64;
  localparam int BEATS       = LINE_W_DEF / MEM_W_DEF;
  localparam int BEATS_LOG2  = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    REQ,
    BURST,
    RESP,
    GUARD
  } state_t;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_BURST
  } pf_state_t;

  function automatic int cnt_width(input int line_w, input int mem_w);
    return $clog2(line_w / mem_w);
  endfunction

endpackage

// File: rtl/imem_line_buf.sv
// Beat counter plus line assembly register: gathers LINE_W/MEM_W memory beats, lowest address first.
module imem_line_buf
  import imem_fill_resp_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int MEM_W  = MEM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_beat_valid,
  input  logic [MEM_W-1:0]  i_beat_data,
  output logic [LINE_W-1:0] o_line,
  output logic              o_done
);

  localparam int NBEATS = LINE_W / MEM_W;
  localparam int CNT_W  = cnt_width(LINE_W, MEM_W);

  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_line <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_beat_valid) begin
      r_line[MEM_W*r_cnt +: MEM_W] <= i_beat_data;
      r_cnt                        <= r_cnt + 1'b1;
    end
  end

  // done flags the beat that completes the line, so the caller can move on in the same cycle
  assign o_done = i_beat_valid && (r_cnt == CNT_W'(NBEATS - 1));
  assign o_line = r_line;

endmodule

// File: rtl/imem_fill_resp.sv
// L2-side responder for L1 I-cache line fills: fetches a line as a memory burst and returns it with a one-cycle pulse.
// Optional next-line prefetch buffer is enabled by defining IMEM_RESP_PREFETCH_EN.
module imem_fill_resp
  import imem_fill_resp_pkg::*;
#(
  parameter int BLK_LEN = BLK_LEN_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int MEM_W   = MEM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLK_LEN-1:0] b_addr_i,
  input  logic               b_rd_i,
  output logic [LINE_W-1:0]  b_data_i,
  output logic               b_dv_i,
  output logic [63:0]        m_addr,
  output logic               m_req,
  input  logic               m_gnt,
  input  logic [MEM_W-1:0]   m_rdata,
  input  logic               m_rvalid
);

  localparam int OFF_W = 64 - BLK_LEN;

  state_t             r_state, w_next;
  logic [BLK_LEN-1:0] r_addr;
  logic               r_abort;
  logic [LINE_W-1:0]  r_bdata;
  logic [LINE_W-1:0]  w_line, w_resp_line;
  logic               w_main_req, w_clear, w_beat, w_done;

  assign w_beat = (r_state == BURST) && m_rvalid;

  imem_line_buf #(.LINE_W(LINE_W), .MEM_W(MEM_W)) u_main_buf (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_beat_valid (w_beat),
    .i_beat_data  (m_rdata),
    .o_line       (w_line),
    .o_done       (w_done)
  );

`ifdef IMEM_RESP_PREFETCH_EN
  pf_state_t          r_pf_state, w_pf_next;
  logic [BLK_LEN-1:0] r_pf_tag;
  logic               r_pf_valid, r_resp_pf;
  logic [LINE_W-1:0]  w_pf_line;
  logic               w_pf_clear, w_pf_beat, w_pf_done, w_pf_busy, w_hit_addr, w_hit_q;

  assign w_pf_busy   = (r_pf_state != PF_IDLE);
  assign w_pf_beat   = (r_pf_state == PF_BURST) && m_rvalid;
  assign w_pf_clear  = (r_pf_state == PF_REQ) && m_gnt;
  assign w_hit_addr  = r_pf_valid && (r_pf_tag == b_addr_i);
  assign w_hit_q     = r_pf_valid && (r_pf_tag == r_addr);
  assign w_resp_line = r_resp_pf ? w_pf_line : w_line;
  assign m_req       = w_main_req || (r_pf_state == PF_REQ);
  assign m_addr      = (r_pf_state == PF_REQ) ? {r_pf_tag, {OFF_W{1'b0}}} : {r_addr, {OFF_W{1'b0}}};

  imem_line_buf #(.LINE_W(LINE_W), .MEM_W(MEM_W)) u_pf_buf (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_pf_clear),
    .i_beat_valid (w_pf_beat),
    .i_beat_data  (m_rdata),
    .o_line       (w_pf_line),
    .o_done       (w_pf_done)
  );

  // The prefetch burst is launched right after every response; the main FSM never requests while it runs
  always_comb begin
    w_pf_next = r_pf_state;
    case (r_pf_state)
      PF_IDLE:  if (r_state == RESP) w_pf_next = PF_REQ;
      PF_REQ:   if (m_gnt) w_pf_next = PF_BURST;
      PF_BURST: if (w_pf_done) w_pf_next = PF_IDLE;
      default:  w_pf_next = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pf_state <= PF_IDLE;
      r_pf_tag   <= '0;
      r_pf_valid <= 1'b0;
      r_resp_pf  <= 1'b0;
    end else begin
      r_pf_state <= w_pf_next;
      if (r_state == RESP) begin
        r_pf_tag   <= r_addr + 1'b1;
        r_pf_valid <= 1'b0;
      end else if (w_pf_done) begin
        r_pf_valid <= 1'b1;
      end
      if (r_state == ADDR) r_resp_pf <= w_hit_addr;
      else if ((r_state == REQ) && w_hit_q) r_resp_pf <= 1'b1;
    end
  end
`else
  assign w_resp_line = w_line;
  assign m_req       = w_main_req;
  assign m_addr      = {r_addr, {OFF_W{1'b0}}};
`endif

  // Main fill FSM; the address is taken in ADDR because the requester presents it a cycle after b_rd_i
  always_comb begin
    w_next     = r_state;
    w_main_req = 1'b0;
    w_clear    = 1'b0;
    b_dv_i     = 1'b0;
    case (r_state)
      IDLE: if (b_rd_i) w_next = ADDR;
      ADDR: begin
`ifdef IMEM_RESP_PREFETCH_EN
        w_next = w_hit_addr ? RESP : REQ;
`else
        w_next = REQ;
`endif
      end
      REQ: begin
`ifdef IMEM_RESP_PREFETCH_EN
        if (w_hit_q) begin
          w_next = RESP;
        end else if (!w_pf_busy) begin
          w_main_req = 1'b1;
          if (m_gnt) begin
            w_clear = 1'b1;
            w_next  = BURST;
          end
        end
`else
        w_main_req = 1'b1;
        if (m_gnt) begin
          w_clear = 1'b1;
          w_next  = BURST;
        end
`endif
      end
      BURST: if (w_done) w_next = (r_abort || !b_rd_i) ? IDLE : RESP;
      RESP: begin
        b_dv_i = !r_abort;
        w_next = GUARD;
      end
      GUARD:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // An abort (b_rd_i dropping mid-fill) lets the burst drain but suppresses the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_abort <= 1'b0;
      r_bdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ADDR) r_addr <= b_addr_i;
      if (r_state == IDLE) r_abort <= 1'b0;
      else if (!b_rd_i && ((r_state == ADDR) || (r_state == REQ) || (r_state == BURST))) r_abort <= 1'b1;
      if ((r_state == RESP) && !r_abort) r_bdata <= w_resp_line;
    end
  end

  assign b_data_i = (r_state == RESP) ? w_resp_line : r_bdata;

endmodule

// File: tb/tb_imem_fill_resp.sv
// Directed self-checking bench for imem_fill_resp (default build, IMEM_RESP_PREFETCH_EN undefined).
module tb_imem_fill_resp;

  logic         clk;
  logic         rst;
  logic [58:0]  b_addr_i;
  logic         b_rd_i;
  logic [255:0] b_data_i;
  logic         b_dv_i;
  logic [63:0]  m_addr;
  logic         m_req;
  logic         m_gnt;
  logic [63:0]  m_rdata;
  logic         m_rvalid;

  int checks;
  int failures;
  int dvCount;

  localparam logic [255:0] LINE1 = {64'h4444444444444444, 64'h3333333333333333,
                                    64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] LINE2 = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                    64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
  localparam logic [255:0] LINEA = {64'h8888888888888888, 64'h7777777777777777,
                                    64'h6666666666666666, 64'h5555555555555555};
  localparam logic [255:0] LINE3 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                    64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0};

  imem_fill_resp dut (
    .clk      (clk),
    .rst      (rst),
    .b_addr_i (b_addr_i),
    .b_rd_i   (b_rd_i),
    .b_data_i (b_data_i),
    .b_dv_i   (b_dv_i),
    .m_addr   (m_addr),
    .m_req    (m_req),
    .m_gnt    (m_gnt),
    .m_rdata  (m_rdata),
    .m_rvalid (m_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (b_dv_i === 1'b1) dvCount++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic [58:0] addr, input logic gnt,
                               input logic rv, input logic [63:0] data);
    b_rd_i   = rd;
    b_addr_i = addr;
    m_gnt    = gnt;
    m_rvalid = rv;
    m_rdata  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sendBeats(input logic [255:0] line, input int gap);
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = line[64*i +: 64];
      tick();
      m_rvalid = 1'b0;
      if (i < 3) repeat (gap) tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    dvCount  = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    repeat (2) tick();
    checkOutput("reset_dv", b_dv_i, 0);
    checkOutput("reset_mreq", m_req, 0);
    checkOutput("reset_maddr", m_addr, 0);
    checkOutput("reset_bdata", b_data_i, 0);
    rst = 1'b0;
    tick();

    $display("[TB] single fill at 0x1234");
    applyStimulus(1'b1, '0, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b1, 59'h1234, 1'b0, 1'b0, '0);
    tick();
    checkOutput("fill1_mreq", m_req, 1);
    checkOutput("fill1_maddr", m_addr, 64'h24680);
    tick();
    checkOutput("fill1_mreq_held", m_req, 1);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    checkOutput("fill1_mreq_drop", m_req, 0);
    sendBeats(LINE1, 0);
    checkOutput("fill1_dv", b_dv_i, 1);
    checkOutput("fill1_data", b_data_i, LINE1);
    tick();
    checkOutput("fill1_guard_dv", b_dv_i, 0);
    checkOutput("fill1_hold_data", b_data_i, LINE1);
    tick();
    b_rd_i = 1'b0;
    checkOutput("fill1_pulses", dvCount, 1);

    $display("[TB] gapped beats");
    tick();
    applyStimulus(1'b1, 59'h1234, 1'b0, 1'b0, '0);
    tick();
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    sendBeats(LINE1, 3);
    checkOutput("gap_dv", b_dv_i, 1);
    checkOutput("gap_data", b_data_i, LINE1);
    tick();
    checkOutput("gap_guard_dv", b_dv_i, 0);
    tick();
    checkOutput("gap_idle_dv", b_dv_i, 0);
    checkOutput("gap_pulses", dvCount, 2);

    $display("[TB] back-to-back request at 0x1235");
    tick();
    b_addr_i = 59'h1235;
    tick();
    checkOutput("b2b_mreq", m_req, 1);
    checkOutput("b2b_maddr", m_addr, 64'h246A0);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    sendBeats(LINE2, 0);
    checkOutput("b2b_dv", b_dv_i, 1);
    checkOutput("b2b_data", b_data_i, LINE2);
    tick();
    b_rd_i = 1'b0;
    tick();
    checkOutput("b2b_pulses", dvCount, 3);

    $display("[TB] abort during beat 2");
    applyStimulus(1'b1, 59'h1235, 1'b0, 1'b0, '0);
    tick();
    b_addr_i = 59'h0100;
    tick();
    checkOutput("abort_maddr", m_addr, 64'h2000);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) b_rd_i = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = LINEA[64*i +: 64];
      tick();
    end
    checkOutput("abort_dv", b_dv_i, 0);
    m_rdata = 64'h9999999999999999;
    tick();
    m_rvalid = 1'b0;
    checkOutput("abort_mreq", m_req, 0);
    tick();
    checkOutput("abort_pulses", dvCount, 3);

    $display("[TB] async reset mid-burst");
    applyStimulus(1'b1, 59'h0100, 1'b0, 1'b0, '0);
    tick();
    b_addr_i = 59'h0200;
    tick();
    checkOutput("rst_pre_mreq", m_req, 1);
    m_gnt = 1'b1;
    tick();
    m_gnt    = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 64'h5A5A5A5A5A5A5A5A;
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_dv", b_dv_i, 0);
    checkOutput("rst_mid_mreq", m_req, 0);
    checkOutput("rst_mid_maddr", m_addr, 0);
    checkOutput("rst_mid_bdata", b_data_i, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    #2 rst = 1'b0;
    tick();
    applyStimulus(1'b1, '0, 1'b0, 1'b0, '0);
    tick();
    b_addr_i = 59'h0300;
    tick();
    checkOutput("rst_after_maddr", m_addr, 64'h6000);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    sendBeats(LINE3, 1);
    checkOutput("rst_after_dv", b_dv_i, 1);
    checkOutput("rst_after_data", b_data_i, LINE3);
    tick();
    b_rd_i = 1'b0;
    tick();
    checkOutput("rst_after_pulses", dvCount, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fill_resp.md
Name: imem_fill_resp

Overview:
- L2-side responder for L1 instruction-cache line fills; the opposite end of the b_addr_i/b_rd_i/b_data_i/b_dv_i interface driven by the I-cache.
- Accepts one line request and fetches the line from a narrower memory port as a burst of MEM_W beats.
- Assembles the beats into a full line and returns it with a single-cycle valid pulse.
- Sits between the hart's L1 I-cache and the memory/L2 arbiter.

Parameters:
- BLK_LEN, 59, line (block) address width in bits (64 - log2(line bytes)).
- LINE_W, 256, cache line width in bits.
- MEM_W, 64, memory data beat width; BEATS = LINE_W/MEM_W (default 4), must be a power of two ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- b_addr_i  in  BLK_LEN  requested line address from the I-cache.
- b_rd_i  in  1  line read request, held high until b_dv_i.
- b_data_i  out  LINE_W  returned line; valid only while b_dv_i=1.
- b_dv_i  out  1  single-cycle line-valid pulse.
- m_addr  out  64  byte address of the burst (line aligned, low bits zero).
- m_req  out  1  burst request, held until m_gnt.
- m_gnt  in  1  burst accepted (one cycle).
- m_rdata  in  MEM_W  beat data, lowest address first.
- m_rvalid  in  1  beat valid; exactly BEATS pulses per granted burst, any spacing.

Behaviour:
- Reset (async on rst rise): state IDLE, b_dv_i=0, m_req=0, beat counter=0, m_addr=0, b_data_i=0.
- States: IDLE, ADDR, REQ, BURST, RESP, GUARD.
- IDLE: b_rd_i=1 -> ADDR. The address is not sampled in this cycle because the requester registers b_addr_i one cycle after raising b_rd_i.
- ADDR: latch addr_q <= b_addr_i; -> REQ.
- REQ: m_req=1, m_addr={addr_q, zeros}. m_gnt=1 -> BURST, beat counter cleared. m_req deasserts the cycle after m_gnt.
- BURST: each m_rvalid writes m_rdata into line slice [MEM_W*cnt +: MEM_W], then cnt++. On the BEATS-th beat -> RESP.
- RESP: b_dv_i=1 for exactly one cycle with the full line on b_data_i; -> GUARD.
- GUARD: one cycle ignoring b_rd_i, because the requester drops b_rd_i one cycle after b_dv_i; -> IDLE.
- Minimum request-to-b_dv_i latency: 4 + m_gnt wait + beat delivery.
- b_rd_i falling before b_dv_i (requester reset): the burst still completes, since the memory cannot abort. The response is suppressed (no b_dv_i); go directly to IDLE.
- m_rvalid outside BURST is ignored. Extra beats after the final beat of a burst are a protocol error and are ignored.
- b_data_i holds the last assembled line between responses.
- rst mid-burst clears all state immediately. The memory side must also be reset by the same rst.

Optional Feature:
- Macro: IMEM_RESP_PREFETCH_EN.
- Defined:
  - After RESP, the block issues a next-line burst for addr_q+1 (wrapping modulo 2^BLK_LEN) into a prefetch buffer, with a tag register and a valid bit.
  - A later request whose latched address equals the tag with valid=1 goes ADDR -> RESP directly, giving latency 3.
  - A non-matching request arriving during a prefetch burst waits for that burst to finish. The prefetch result is then stored as valid, and the new request proceeds to REQ.
  - The prefetch valid bit is cleared on rst.
- Undefined: no prefetch logic; the behaviour is exactly as in Behaviour.

Decomposition:
- Shared package (config include): state encodings, BEATS and log2(BEATS), and default BLK_LEN/LINE_W/MEM_W, shared with the I-cache configuration.
- One natural sub-module, imem_line_buf: beat counter plus line assembly register, with inputs clear, beat valid, and beat data, and outputs the line and a done flag.
- The prefetch variant instantiates imem_line_buf twice.

Test Plan:
- Single fill: b_rd_i=1, b_addr_i=0x1234 one cycle later; m_gnt after 2 cycles; beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> m_addr=0x24680 (0x1234 shifted left by 5), then one b_dv_i pulse with b_data_i={0x44..,0x33..,0x22..,0x11..}.
- Gapped beats: 3 idle cycles between each m_rvalid -> identical line; exactly one b_dv_i pulse; no second pulse during GUARD although b_rd_i is still high there.
- Back-to-back requests: new b_rd_i the cycle after GUARD at address 0x1235 -> m_addr=0x246A0; correct second line.
- Abort: b_rd_i drops during BURST beat 2 -> remaining beats are consumed, b_dv_i never asserts, state returns to IDLE.
- Async reset: rst pulsed mid-cycle during BURST -> b_dv_i=0 and m_req=0 immediately; the next request is served correctly from beat 0.
- IMEM_RESP_PREFETCH_EN: fill 0x10, then request 0x11 after the prefetch completes -> b_dv_i 3 cycles after b_rd_i with no new m_req. A request for 0x40 during the prefetch is served only after the prefetch's 4 beats.
